fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 39 +++
 rtl/pc_next.sv | 30 +++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Definitions shared between the fetch unit and the controller: reset vector,
// fetch FSM states, the redirect control bundle, and MIPS opcode/func values.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // ST_RESET is the reset-held condition; FETCH begins one edge after release.
    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_HOLD,
        ST_HALTED
    } fetch_state_e;

    typedef struct packed {
        logic halt;
        logic jump_register;
        logic jump;
        logic branch;
        logic branch_taken;
    } redirect_t;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select for a retired instruction.
// Priority: JR, then J/JAL, then taken branch, else sequential.
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc_out,
    input  logic [31:0] instr,
    input  redirect_t   ctrl,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic        unused_bits;

    // The opcode and halt are consumed elsewhere; halt is resolved by the FSM.
    assign unused_bits = ^{instr[31:26], ctrl.halt};
    assign pc4         = pc_out + 32'd4;

    always_comb begin
        next_pc = pc4;
        if (ctrl.jump_register)
            next_pc = jr_target & 32'hFFFF_FFFC;
        else if (ctrl.jump)
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
        else if (ctrl.branch && ctrl.branch_taken)
            next_pc = pc4 + br_offset(instr[15:0]);
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request a word, hold it for decode,
// then redirect or advance on the decode handshake. Halt is terminal until reset.
module fetch_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        jump_register,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic        halted
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         rsp_take;
    logic         hs;
    redirect_t    ctrl;

    assign ctrl = '{halt:          halt,
                    jump_register: jump_register,
                    jump:          jump,
                    branch:        branch,
                    branch_taken:  branch_taken};

    // imem_ready only counts while a request is out; controls only at handshake.
    assign rsp_take = (state == ST_FETCH) && imem_ready;
    assign hs       = (state == ST_HOLD) && instr_ready;

    pc_next u_pc_next (
        .pc_out    (pc_out),
        .instr     (instr),
        .ctrl      (ctrl),
        .jr_target (jr_target),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_RESET;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_FETCH;
            ST_FETCH:  if (imem_ready) state_nxt = ST_HOLD;
            ST_HOLD:   if (instr_ready) state_nxt = halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc     <= RESET_VECTOR;
            instr  <= '0;
            pc_out <= '0;
        end else begin
            if (rsp_take) begin
                instr  <= imem_rdata;
                pc_out <= pc;
            end
            if (hs && !halt)
                pc <= next_pc;
        end
    end

    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = {pc[31:2], 2'b00};
    assign instr_valid = (state == ST_HOLD);
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model and
// hand-computed expected addresses/instructions for each scenario.
module tb_fetch_unit;

    logic        clk;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_ready;
    logic        jump;
    logic        jump_register;
    logic        branch;
    logic        branch_taken;
    logic [31:0] jr_target;
    logic        halt;
    logic        halted;

    int n_chk  = 0;
    int n_pass = 0;
    int mem_lat = 0;
    int wait_cnt = 0;
    logic force_ready = 1'b0;

    fetch_unit dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc_out        (pc_out),
        .instr_ready   (instr_ready),
        .jump          (jump),
        .jump_register (jump_register),
        .branch        (branch),
        .branch_taken  (branch_taken),
        .jr_target     (jr_target),
        .halt          (halt),
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h8C09_0004;
            32'h0000_0100: return 32'h1000_FFFE;
            32'h1000_0040: return 32'h0800_0010;
            default:       return 32'h0000_0020;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!imem_req || imem_ready) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    assign imem_ready = force_ready | (imem_req && (wait_cnt >= mem_lat));
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Called on a negedge with instr_valid=1; returns on the negedge after the handshake.
    task automatic hs(input logic jr, input logic j, input logic br, input logic tk,
                      input logic h, input logic [31:0] tgt);
        jump_register = jr; jump = j; branch = br; branch_taken = tk; halt = h;
        jr_target = tgt; instr_ready = 1'b1;
        @(negedge clk);
        {jump_register, jump, branch, branch_taken, halt} = '0;
        jr_target = 32'hDEAD_BEEF; instr_ready = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; instr_ready = 1'b0;
        {jump_register, jump, branch, branch_taken, halt} = '0;
        jr_target = 32'hDEAD_BEEF;
        @(negedge clk); @(negedge clk);
        chk("rst_req",    {31'd0, imem_req},    32'd0);
        chk("rst_addr",   imem_addr,            32'd0);
        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_instr",  instr,                32'd0);
        chk("rst_pc_out", pc_out,               32'd0);
        chk("rst_halted", {31'd0, halted},      32'd0);

        // Reset release, zero-latency memory
        rst_b = 1'b1;
        @(negedge clk);
        chk("rel_req",  {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr,         32'd0);
        @(negedge clk);
        chk("first_valid",  {31'd0, instr_valid}, 32'd1);
        chk("first_instr",  instr,                32'h2008_0005);
        chk("first_pc_out", pc_out,               32'd0);
        hs(0, 0, 0, 0, 0, 32'd0);
        chk("seq_addr",  imem_addr,            32'h4);
        chk("seq_req",   {31'd0, imem_req},    32'd1);
        chk("seq_valid", {31'd0, instr_valid}, 32'd0);

        // 3-cycle memory, decode stalls 5 cycles; controls in HOLD must be ignored
        mem_lat = 3;
        wait_valid("lat3");
        chk("lat3_instr",  instr,  32'h8C09_0004);
        chk("lat3_pc_out", pc_out, 32'h4);
        for (int i = 0; i < 5; i++) begin
            halt = (i < 2); jump = (i < 2);
            @(negedge clk);
            chk("hold_req",   {31'd0, imem_req},    32'd0);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr,                32'h8C09_0004);
            chk("hold_pc",    pc_out,               32'h4);
        end
        halt = 1'b0; jump = 1'b0;
        chk("hold_not_halted", {31'd0, halted}, 32'd0);
        mem_lat = 0;

        // Branch taken / not taken from 0x100
        hs(1, 0, 0, 0, 0, 32'h0000_0103);
        chk("jr_addr", imem_addr, 32'h100);
        wait_valid("br1");
        chk("br_pc_out", pc_out, 32'h100);
        hs(0, 0, 1, 1, 0, 32'd0);
        chk("br_taken_addr", imem_addr, 32'hFC);
        wait_valid("fc");
        hs(0, 0, 0, 0, 0, 32'd0);
        chk("fc_seq_addr", imem_addr, 32'h100);
        wait_valid("br2");
        hs(0, 0, 1, 0, 0, 32'd0);
        chk("br_not_taken_addr", imem_addr, 32'h104);

        // Jump and JR-over-jump priority from 0x1000_0040
        wait_valid("to_j");
        hs(1, 0, 0, 0, 0, 32'h1000_0040);
        chk("jr2_addr", imem_addr, 32'h1000_0040);
        wait_valid("j1");
        chk("j_instr", instr, 32'h0800_0010);
        hs(0, 1, 0, 0, 0, 32'd0);
        chk("j_addr", imem_addr, 32'h1000_0040);
        wait_valid("j2");
        hs(1, 1, 0, 0, 0, 32'h0000_0203);
        chk("jr_prio_addr", imem_addr, 32'h200);

        // PC wrap at top of address space
        wait_valid("to_wrap");
        hs(1, 0, 0, 0, 0, 32'hFFFF_FFFF);
        chk("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap");
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        hs(0, 0, 0, 0, 0, 32'd0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Halt beats jump
        wait_valid("halt");
        hs(0, 1, 0, 0, 1, 32'd0);
        chk("halted",       {31'd0, halted},      32'd1);
        chk("halt_req",     {31'd0, imem_req},    32'd0);
        chk("halt_valid",   {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_stay_req", {31'd0, imem_req}, 32'd0);
        end
        rst_b = 1'b0;
        #1;
        chk("halt_rst_clear", {31'd0, halted}, 32'd0);
        mem_lat = 3;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("resume_req",  {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr,         32'd0);

        // Reset collides with a memory response mid-request
        rst_b = 1'b0; force_ready = 1'b1;
        #1;
        chk("mid_rst_req",   {31'd0, imem_req},    32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("mid_rst_valid2", {31'd0, instr_valid}, 32'd0);
        force_ready = 1'b0; rst_b = 1'b1;
        @(negedge clk);
        chk("restart_req",   {31'd0, imem_req},    32'd1);
        chk("restart_addr",  imem_addr,            32'd0);
        chk("restart_valid", {31'd0, instr_valid}, 32'd0);
        mem_lat = 0;
        wait_valid("restart");
        chk("restart_instr", instr, 32'h2008_0005);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
